// File: rtl/tnn_pkg.sv
// Shared types and helpers for the temporal-neural-network column.
// Spike times carry a "no spike" flag in their MSB; the low bits are the time.
package tnn_pkg;

  localparam int unsigned TNN_LOG_T = 3;
  localparam int unsigned TNN_TW    = TNN_LOG_T + 1;

  typedef logic [TNN_TW-1:0] spike_time_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    UPDATE,
    OUTPUT
  } state_t;

  // The width argument lets each instance use its own window size.
  function automatic logic NO_SPIKE(input logic [31:0] t, input int unsigned tw);
    return ((t >> (tw - 1)) & 32'd1) != 32'd0;
  endfunction

  function automatic logic SPIKED(input logic [31:0] t, input int unsigned tw);
    return ((t >> (tw - 1)) & 32'd1) == 32'd0;
  endfunction

endpackage

// File: rtl/tnn_stdp_unit.sv
// Combinational STDP update for one neuron: P weights in, P weights out.
// Capture/backoff apply when this neuron fired; search applies when it did not.
module tnn_stdp_unit
  import tnn_pkg::*;
#(
  parameter int unsigned P         = 8,
  parameter int unsigned WBITS     = 3,
  parameter int unsigned TW        = 4,
  parameter bit          SEARCH_EN = 1'b1
) (
  input  logic [P-1:0][WBITS-1:0] w_in,
  input  logic [P-1:0][TW-1:0]    x_times,
  input  logic [TW-1:0]           y,
  input  logic                    fired,
  output logic [P-1:0][WBITS-1:0] w_out
);

  localparam logic [WBITS-1:0] WMAX = '1;

  always_comb begin
    w_out = w_in;
    for (int i = 0; i < P; i++) begin
      // Both times are real spikes here, so a full-width compare is safe.
      if (fired && SPIKED(32'(x_times[i]), TW) && (x_times[i] <= y)) begin
        if (w_in[i] != WMAX) w_out[i] = w_in[i] + 1'b1;
      end else if (fired) begin
        if (w_in[i] != '0) w_out[i] = w_in[i] - 1'b1;
      end else if (SEARCH_EN && SPIKED(32'(x_times[i]), TW)) begin
        if (w_in[i] != WMAX) w_out[i] = w_in[i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tnn_column.sv
// Temporal-neural-network column: Q step-response neurons over a T-cycle window,
// first-to-fire winner-take-all, optional STDP and test access to the weights.
module tnn_column
  import tnn_pkg::*;
#(
  parameter int unsigned P         = 8,
  parameter int unsigned Q         = 4,
  parameter int unsigned WBITS     = 3,
  parameter int unsigned LOG_T     = 3,
  parameter int unsigned THRESH    = 8,
  parameter int unsigned W_INIT    = 4,
  parameter bit          SEARCH_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [P-1:0][LOG_T:0]      in_times,
  input  logic                       in_train,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LOG_T:0]             out_time,
  output logic [$clog2(Q)-1:0]       out_winner,
  input  logic                       wr_en,
  input  logic [$clog2(Q)-1:0]       wr_neuron,
  input  logic [$clog2(P)-1:0]       wr_syn,
  input  logic [WBITS-1:0]           wr_data,
  input  logic [$clog2(Q)-1:0]       rd_neuron,
  input  logic [$clog2(P)-1:0]       rd_syn,
  output logic [WBITS-1:0]           rd_data
);

  localparam int unsigned TW = LOG_T + 1;
  localparam int unsigned QW = $clog2(Q);
  localparam int unsigned PW = WBITS + $clog2(P + 1);
  localparam logic [TW-1:0] NONE_TIME = {1'b1, {LOG_T{1'b0}}};

  state_t state, state_nxt;

  logic [LOG_T-1:0]               t;
  logic [P-1:0][TW-1:0]           times_q;
  logic                           train_q;
  logic [Q-1:0][P-1:0][WBITS-1:0] w;
  logic [QW-1:0]                  upd_j;
  logic [TW-1:0]                  y_q;
  logic [QW-1:0]                  win_q;
  logic                           fired_q;

  logic [PW-1:0]                  pot [Q];
  logic [Q-1:0]                   fire_vec;
  logic                           any_fire;
  logic [QW-1:0]                  first_idx;
  logic                           last_t;
  logic                           compute_done;
  logic                           update_last;
  logic [TW-1:0]                  comb_y;
  logic [QW-1:0]                  comb_win;
  logic                           upd_hit;
  logic [TW-1:0]                  upd_y;
  logic [P-1:0][WBITS-1:0]        w_new;

  // Step-response potentials: every input that has already spiked contributes its weight.
  always_comb begin
    for (int j = 0; j < Q; j++) begin
      pot[j] = '0;
      for (int i = 0; i < P; i++) begin
        if (SPIKED(32'(times_q[i]), TW) && (times_q[i][LOG_T-1:0] <= t))
          pot[j] = pot[j] + PW'(w[j][i]);
      end
      fire_vec[j] = (pot[j] >= PW'(THRESH));
    end
  end

  always_comb begin
    first_idx = '0;
    for (int j = Q - 1; j >= 0; j--) begin
      if (fire_vec[j]) first_idx = QW'(j);
    end
  end

  assign any_fire     = |fire_vec;
  assign last_t       = &t;
  assign compute_done = any_fire || last_t;
  assign update_last  = (upd_j == QW'(Q - 1));
  assign comb_y       = any_fire ? {1'b0, t} : NONE_TIME;
  assign comb_win     = any_fire ? first_idx : '0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (compute_done) state_nxt = train_q ? UPDATE : OUTPUT;
      end
      UPDATE: begin
        if (update_last) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the winner learns as "fired"; every other neuron sees no output spike.
  assign upd_hit = fired_q && (upd_j == win_q);
  assign upd_y   = upd_hit ? y_q : NONE_TIME;

  tnn_stdp_unit #(
    .P         (P),
    .WBITS     (WBITS),
    .TW        (TW),
    .SEARCH_EN (SEARCH_EN)
  ) u_stdp (
    .w_in    (w[upd_j]),
    .x_times (times_q),
    .y       (upd_y),
    .fired   (upd_hit),
    .w_out   (w_new)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      t          <= '0;
      times_q    <= '0;
      train_q    <= 1'b0;
      w          <= {(Q * P){WBITS'(W_INIT)}};
      upd_j      <= '0;
      y_q        <= '0;
      win_q      <= '0;
      fired_q    <= 1'b0;
      out_time   <= '0;
      out_winner <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write lands on the same edge as an accept, so the volley sees it.
          if (wr_en) w[wr_neuron][wr_syn] <= wr_data;
          if (in_valid) begin
            times_q <= in_times;
            train_q <= in_train;
            t       <= '0;
          end
        end
        COMPUTE: begin
          if (compute_done) begin
            y_q     <= comb_y;
            win_q   <= comb_win;
            fired_q <= any_fire;
            upd_j   <= '0;
            if (!train_q) begin
              out_time   <= comb_y;
              out_winner <= comb_win;
            end
          end else begin
            t <= t + 1'b1;
          end
        end
        UPDATE: begin
          w[upd_j] <= w_new;
          if (update_last) begin
            upd_j      <= '0;
            out_time   <= y_q;
            out_winner <= win_q;
          end else begin
            upd_j <= upd_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = w[rd_neuron][rd_syn];

endmodule

// File: tb/tb_tnn_column.sv
// Directed, scoreboard-based bench for tnn_column with P=4, Q=2, THRESH=6, W_INIT=4.
// Expected fire time, winner, latency and weights come from a behavioural model.
module tb_tnn_column;
  import tnn_pkg::*;

  localparam spike_time_t NONE = 4'b1000;

  logic             clk;
  logic             rst_l;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][3:0]  in_times;
  logic             in_train;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_time;
  logic             out_winner;
  logic             wr_en;
  logic             wr_neuron;
  logic [1:0]       wr_syn;
  logic [2:0]       wr_data;
  logic             rd_neuron;
  logic [1:0]       rd_syn;
  logic [2:0]       rd_data;

  typedef struct {
    logic [3:0] yt;
    logic       win;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   wm [2][4];
  int   n_cmp;
  int   n_err;

  tnn_column #(
    .P(4), .Q(2), .WBITS(3), .LOG_T(3), .THRESH(6), .W_INIT(4), .SEARCH_EN(1'b1)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_times   (in_times),
    .in_train   (in_train),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_time   (out_time),
    .out_winner (out_winner),
    .wr_en      (wr_en),
    .wr_neuron  (wr_neuron),
    .wr_syn     (wr_syn),
    .wr_data    (wr_data),
    .rd_neuron  (rd_neuron),
    .rd_syn     (rd_syn),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0][3:0] vol(input spike_time_t a, input spike_time_t b,
                                          input spike_time_t c, input spike_time_t d);
    logic [3:0][3:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  // Behavioural forward pass plus STDP; returns expectations and updates wm.
  function automatic exp_t model_volley(input logic [3:0][3:0] tm, input bit train);
    exp_t e;
    bit   fired;
    int   sum;
    int   tf;
    fired = 1'b0;
    e.win = 1'b0;
    e.yt  = NONE;
    tf    = 7;
    for (int tt = 0; tt < 8 && !fired; tt++) begin
      for (int j = 0; j < 2 && !fired; j++) begin
        sum = 0;
        for (int i = 0; i < 4; i++)
          if (!tm[i][3] && int'(tm[i][2:0]) <= tt) sum += wm[j][i];
        if (sum >= 6) begin
          fired = 1'b1;
          e.win = 1'(j);
          e.yt  = 4'(tt);
          tf    = tt;
        end
      end
    end
    e.lat = 1 + tf + (train ? 2 : 0);
    if (train) begin
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < 4; i++) begin
          if (fired && j == int'(e.win)) begin
            if (!tm[i][3] && tm[i][2:0] <= e.yt[2:0]) wm[j][i] = (wm[j][i] < 7) ? wm[j][i] + 1 : 7;
            else                                      wm[j][i] = (wm[j][i] > 0) ? wm[j][i] - 1 : 0;
          end else if (!tm[i][3]) begin
            wm[j][i] = (wm[j][i] < 7) ? wm[j][i] + 1 : 7;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic apply_stimulus(input logic [3:0][3:0] tm, input bit train);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_times = tm;
    in_train = train;
    sb.push_back(model_volley(tm, train));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_train = 1'b0;
  endtask

  // Latency counts edges after the accept edge; a fire at tf gives 1+tf (+Q when training).
  task automatic check_output(input string tag, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      wr_en = 1'b0;
    end
    e = sb.pop_front();
    check({tag, "_valid"},  32'(out_valid),  32'd1);
    check({tag, "_lat"},    32'(lat),        32'(e.lat));
    check({tag, "_time"},   32'(out_time),   32'(e.yt));
    check({tag, "_winner"}, 32'(out_winner), 32'(e.win));
    check({tag, "_busy"},   32'(in_ready),   32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid),  32'd1);
      check({tag, "_hold_time"},  32'(out_time),   32'(e.yt));
      check({tag, "_hold_win"},   32'(out_winner), 32'(e.win));
      check({tag, "_hold_busy"},  32'(in_ready),   32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(in_ready),  32'd1);
    check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_weights(input string tag);
    for (int q = 0; q < 2; q++) begin
      for (int p = 0; p < 4; p++) begin
        rd_neuron = 1'(q);
        rd_syn    = 2'(p);
        #1;
        check($sformatf("%s_w%0d%0d", tag, q, p), 32'(rd_data), 32'(wm[q][p]));
      end
    end
  endtask

  task automatic write_weight(input int n, input int s, input int d);
    @(negedge clk);
    wr_en     = 1'b1;
    wr_neuron = 1'(n);
    wr_syn    = 2'(s);
    wr_data   = 3'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wm[n][s] = d;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_l     = 1'b0;
    in_valid  = 1'b0;
    in_times  = '0;
    in_train  = 1'b0;
    out_ready = 1'b0;
    wr_en     = 1'b0;
    wr_neuron = 1'b0;
    wr_syn    = '0;
    wr_data   = '0;
    rd_neuron = 1'b0;
    rd_syn    = '0;
    for (int q = 0; q < 2; q++)
      for (int p = 0; p < 4; p++) wm[q][p] = 4;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",   32'(in_ready),   32'd1);
    check("reset_out_valid",  32'(out_valid),  32'd0);
    check("reset_out_time",   32'(out_time),   32'd0);
    check("reset_out_winner", 32'(out_winner), 32'd0);
    check_weights("reset");
    @(negedge clk);
    rst_l = 1'b1;

    $display("[TB] inference, tie resolved to neuron 0");
    apply_stimulus(vol(4'd0, 4'd1, NONE, NONE), 1'b0);
    check_output("infer", 0);
    check_weights("infer");

    $display("[TB] same volley with training");
    apply_stimulus(vol(4'd0, 4'd1, NONE, NONE), 1'b1);
    check_output("train", 0);
    check_weights("train");

    $display("[TB] silent volley with training, output held for 5 cycles");
    apply_stimulus(vol(NONE, NONE, NONE, NONE), 1'b1);
    check_output("nofire", 5);
    check_weights("nofire");

    $display("[TB] saturation, write ignored outside IDLE");
    write_weight(0, 0, 7);
    write_weight(0, 1, 7);
    write_weight(0, 2, 0);
    write_weight(0, 3, 0);
    apply_stimulus(vol(4'd0, 4'd0, NONE, NONE), 1'b1);
    wr_en     = 1'b1;
    wr_neuron = 1'b1;
    wr_syn    = 2'd0;
    wr_data   = 3'd0;
    check_output("sat", 0);
    check_weights("sat");

    $display("[TB] reset in the middle of COMPUTE");
    apply_stimulus(vol(NONE, NONE, NONE, NONE), 1'b0);
    @(posedge clk); #1;
    check("mid_busy", 32'(in_ready), 32'd0);
    rst_l = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_time",  32'(out_time),  32'd0);
    sb.delete();
    for (int q = 0; q < 2; q++)
      for (int p = 0; p < 4; p++) wm[q][p] = 4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    check_weights("mid_rst");

    $display("[TB] recovery volley after reset");
    apply_stimulus(vol(4'd2, 4'd3, 4'd1, NONE), 1'b0);
    check_output("recover", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
